// File: rtl/enemy_missile_launch_scheduler_if.sv
// Launch-scheduler signal bundle between the game-state controller, the missile
// datapath and the scheduler itself.
interface enemy_missile_launch_scheduler_if;
  logic       wave_start;
  logic [2:0] target_sel;
  logic       missile_done;
  logic       launch_ready;
  logic       launch_valid;
  logic [1:0] launch_target;
  logic [3:0] active_count;
  logic [3:0] missiles_left;
  logic       wave_active;
  logic       wave_done;

  modport master (
    output wave_start, target_sel, missile_done, launch_ready,
    input  launch_valid, launch_target, active_count, missiles_left,
           wave_active, wave_done
  );

  modport slave (
    input  wave_start, target_sel, missile_done, launch_ready,
    output launch_valid, launch_target, active_count, missiles_left,
           wave_active, wave_done
  );
endinterface

// File: rtl/enemy_missile_launch_scheduler.sv
// Sequences one wave of enemy missile launches: fixed spacing between launch
// decisions, an in-flight cap, and a target latched at each decision.
module enemy_missile_launch_scheduler #(
  parameter int unsigned MISSILES_PER_WAVE = 8,
  parameter int unsigned MAX_ACTIVE        = 4,
  parameter int unsigned INTERVAL          = 1000,
  parameter int unsigned TMR_W             = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  enemy_missile_launch_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LAUNCH,
    S_DRAIN
  } state_e;

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(INTERVAL - 1);
  localparam logic [3:0]       WAVE_LEN   = 4'(MISSILES_PER_WAVE);
  localparam logic [3:0]       CAP        = 4'(MAX_ACTIVE);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             launch_valid_q, launch_valid_d;
  logic [1:0]       launch_target_q, launch_target_d;
  logic [3:0]       active_count_q, active_count_d;
  logic [3:0]       missiles_left_q, missiles_left_d;
  logic             wave_active_q, wave_active_d;
  logic             wave_done_q, wave_done_d;
  logic             handshake;

  assign handshake = launch_valid_q & bus.launch_ready;

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    launch_valid_d  = launch_valid_q;
    launch_target_d = launch_target_q;
    missiles_left_d = missiles_left_q;
    wave_active_d   = wave_active_q;
    wave_done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.wave_start) begin
          missiles_left_d = WAVE_LEN;
          timer_d         = TMR_RELOAD;
          wave_active_d   = 1'b1;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        // Timer parks at zero while capacity is full, so the launch fires as
        // soon as a slot frees.
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (active_count_q < CAP) begin
          launch_target_d = (bus.target_sel <= 3'd2) ? bus.target_sel[1:0] : 2'd0;
          launch_valid_d  = 1'b1;
          state_d         = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (handshake) begin
          launch_valid_d  = 1'b0;
          missiles_left_d = missiles_left_q - 1'b1;
          if (missiles_left_q == 4'd1) begin
            state_d = S_DRAIN;
          end else begin
            timer_d = TMR_RELOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_DRAIN: begin
        if (active_count_q == '0) begin
          wave_done_d   = 1'b1;
          wave_active_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active_count_d = active_count_q;
    if (handshake && !bus.missile_done) begin
      if (active_count_q < CAP) active_count_d = active_count_q + 4'd1;
    end else if (!handshake && bus.missile_done && (active_count_q != '0)) begin
      active_count_d = active_count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      launch_valid_q  <= 1'b0;
      launch_target_q <= '0;
      active_count_q  <= '0;
      missiles_left_q <= '0;
      wave_active_q   <= 1'b0;
      wave_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      launch_valid_q  <= launch_valid_d;
      launch_target_q <= launch_target_d;
      active_count_q  <= active_count_d;
      missiles_left_q <= missiles_left_d;
      wave_active_q   <= wave_active_d;
      wave_done_q     <= wave_done_d;
    end
  end

  assign bus.launch_valid  = launch_valid_q;
  assign bus.launch_target = launch_target_q;
  assign bus.active_count  = active_count_q;
  assign bus.missiles_left = missiles_left_q;
  assign bus.wave_active   = wave_active_q;
  assign bus.wave_done     = wave_done_q;

endmodule

// File: tb/tb_enemy_missile_launch_scheduler.sv
// Bench for enemy_missile_launch_scheduler: directed scenarios plus randomized
// traffic compared against an absolute-time reference model.
module tb_enemy_missile_launch_scheduler;
  localparam int WAVE = 3;
  localparam int MAXA = 2;
  localparam int IVL  = 4;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  enemy_missile_launch_scheduler_if bus ();

  enemy_missile_launch_scheduler #(
    .MISSILES_PER_WAVE(WAVE),
    .MAX_ACTIVE(MAXA),
    .INTERVAL(IVL),
    .TMR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: launch decisions scheduled by absolute cycle number.
  longint cyc;
  longint m_earliest;
  int     m_left;
  int     m_count;
  int     m_tgt;
  bit     m_wact;
  bit     m_valid;
  bit     m_done;
  bit     m_drain;

  task automatic model_reset();
    m_left = 0; m_count = 0; m_tgt = 0;
    m_wact = 0; m_valid = 0; m_done = 0; m_drain = 0;
    m_earliest = 0;
  endtask

  task automatic step();
    bit hs;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      hs = m_valid && bus.launch_ready;
      m_done = 0;
      if (!m_wact) begin
        if (bus.wave_start) begin
          m_left = WAVE; m_wact = 1; m_earliest = cyc + IVL;
        end
      end else if (m_valid) begin
        if (bus.launch_ready) begin
          m_valid = 0;
          m_left--;
          if (m_left == 0) m_drain = 1;
          else m_earliest = cyc + IVL;
        end
      end else if (m_drain) begin
        if (m_count == 0) begin
          m_done = 1; m_wact = 0; m_drain = 0;
        end
      end else if (cyc >= m_earliest && m_count < MAXA) begin
        m_valid = 1;
        m_tgt = (bus.target_sel <= 3'd2) ? int'(bus.target_sel) : 0;
      end
      if (hs && !bus.missile_done) begin
        if (m_count < MAXA) m_count++;
      end else if (!hs && bus.missile_done && m_count > 0) begin
        m_count--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    bus.wave_start = 0; bus.target_sel = 0; bus.missile_done = 0; bus.launch_ready = 1;
    rst = 1;
    model_reset();
    step();
    step();
    rst = 0;
  endtask

  task automatic start_wave();
    bus.wave_start = 1;
    step();
    bus.wave_start = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.launch_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", bus.launch_valid); end
    tests_run++; if (bus.active_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", bus.active_count); end
    tests_run++; if (bus.missiles_left !== 4'd0) begin tests_failed++; $display("FAIL reset_left: got %0d expected 0", bus.missiles_left); end
    tests_run++; if (bus.wave_active !== 1'b0 || bus.wave_done !== 1'b0) begin tests_failed++; $display("FAIL reset_wave: got active=%0b done=%0b expected 0 0", bus.wave_active, bus.wave_done); end
    tests_run++; if (bus.launch_target !== 2'd0) begin tests_failed++; $display("FAIL reset_target: got %0d expected 0", bus.launch_target); end
  endtask

  task automatic test_latency();
    do_reset();
    bus.target_sel = 3'd1;
    start_wave();
    tests_run++; if (bus.wave_active !== 1'b1 || bus.missiles_left !== 4'd3) begin tests_failed++; $display("FAIL lat_start: got active=%0b left=%0d expected 1 3", bus.wave_active, bus.missiles_left); end
    repeat (3) step();
    tests_run++; if (bus.launch_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_e3_valid: got %0b expected 0", bus.launch_valid); end
    step();
    tests_run++; if (bus.launch_valid !== 1'b1 || bus.launch_target !== 2'd1) begin tests_failed++; $display("FAIL lat_e4: got valid=%0b tgt=%0d expected 1 1", bus.launch_valid, bus.launch_target); end
    step();
    tests_run++; if (bus.launch_valid !== 1'b0 || bus.active_count !== 4'd1 || bus.missiles_left !== 4'd2) begin tests_failed++; $display("FAIL lat_e5_hs: got valid=%0b cnt=%0d left=%0d expected 0 1 2", bus.launch_valid, bus.active_count, bus.missiles_left); end
    repeat (3) step();
    tests_run++; if (bus.launch_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_e8_valid: got %0b expected 0", bus.launch_valid); end
    step();
    tests_run++; if (bus.launch_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_e9_valid: got %0b expected 1", bus.launch_valid); end
  endtask

  task automatic test_capacity();
    do_reset();
    bus.target_sel = 3'd2;
    start_wave();
    repeat (10) step();
    tests_run++; if (bus.active_count !== 4'd2 || bus.missiles_left !== 4'd1) begin tests_failed++; $display("FAIL cap_e10: got cnt=%0d left=%0d expected 2 1", bus.active_count, bus.missiles_left); end
    repeat (8) step();
    tests_run++; if (bus.launch_valid !== 1'b0 || bus.active_count !== 4'd2) begin tests_failed++; $display("FAIL cap_stall: got valid=%0b cnt=%0d expected 0 2", bus.launch_valid, bus.active_count); end
    bus.missile_done = 1;
    step();
    bus.missile_done = 0;
    tests_run++; if (bus.active_count !== 4'd1 || bus.launch_valid !== 1'b0) begin tests_failed++; $display("FAIL cap_free: got cnt=%0d valid=%0b expected 1 0", bus.active_count, bus.launch_valid); end
    step();
    tests_run++; if (bus.launch_valid !== 1'b1 || bus.launch_target !== 2'd2) begin tests_failed++; $display("FAIL cap_relaunch: got valid=%0b tgt=%0d expected 1 2", bus.launch_valid, bus.launch_target); end
    step();
    tests_run++; if (bus.missiles_left !== 4'd0 || bus.active_count !== 4'd2 || bus.wave_active !== 1'b1) begin tests_failed++; $display("FAIL cap_drain: got left=%0d cnt=%0d active=%0b expected 0 2 1", bus.missiles_left, bus.active_count, bus.wave_active); end
    repeat (5) step();
    tests_run++; if (bus.wave_done !== 1'b0 || bus.wave_active !== 1'b1 || bus.launch_valid !== 1'b0) begin tests_failed++; $display("FAIL cap_hold_drain: got done=%0b active=%0b valid=%0b expected 0 1 0", bus.wave_done, bus.wave_active, bus.launch_valid); end
  endtask

  task automatic test_backpressure();
    logic [2:0] sels [3];
    sels[0] = 3'd0; sels[1] = 3'd2; sels[2] = 3'd7;
    do_reset();
    bus.launch_ready = 0;
    bus.target_sel = 3'd1;
    start_wave();
    repeat (4) step();
    tests_run++; if (bus.launch_valid !== 1'b1 || bus.launch_target !== 2'd1) begin tests_failed++; $display("FAIL bp_req: got valid=%0b tgt=%0d expected 1 1", bus.launch_valid, bus.launch_target); end
    for (int i = 0; i < 5; i++) begin
      bus.target_sel = sels[i % 3];
      step();
      tests_run++; if (bus.launch_valid !== 1'b1 || bus.launch_target !== 2'd1 || bus.missiles_left !== 4'd3) begin tests_failed++; $display("FAIL bp_hold%0d: got valid=%0b tgt=%0d left=%0d expected 1 1 3", i, bus.launch_valid, bus.launch_target, bus.missiles_left); end
    end
    bus.launch_ready = 1;
    step();
    tests_run++; if (bus.launch_valid !== 1'b0 || bus.missiles_left !== 4'd2 || bus.active_count !== 4'd1) begin tests_failed++; $display("FAIL bp_hs: got valid=%0b left=%0d cnt=%0d expected 0 2 1", bus.launch_valid, bus.missiles_left, bus.active_count); end
    repeat (2) step();
    tests_run++; if (bus.missiles_left !== 4'd2 || bus.active_count !== 4'd1) begin tests_failed++; $display("FAIL bp_once: got left=%0d cnt=%0d expected 2 1", bus.missiles_left, bus.active_count); end
  endtask

  task automatic test_invalid_drain();
    bit seen;
    do_reset();
    bus.target_sel = 3'd5;
    start_wave();
    repeat (4) step();
    tests_run++; if (bus.launch_valid !== 1'b1 || bus.launch_target !== 2'd0) begin tests_failed++; $display("FAIL inv_tgt: got valid=%0b tgt=%0d expected 1 0", bus.launch_valid, bus.launch_target); end
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      bus.missile_done = (m_count > 0 && $urandom_range(0, 3) == 0);
      step();
      bus.missile_done = 0;
      if (bus.wave_done === 1'b1) begin
        seen = 1;
        tests_run++; if (bus.wave_active !== 1'b0 || bus.active_count !== 4'd0 || bus.missiles_left !== 4'd0) begin tests_failed++; $display("FAIL drain_done: got active=%0b cnt=%0d left=%0d expected 0 0 0", bus.wave_active, bus.active_count, bus.missiles_left); end
        step();
        tests_run++; if (bus.wave_done !== 1'b0 || bus.wave_active !== 1'b0) begin tests_failed++; $display("FAIL drain_pulse: got done=%0b active=%0b expected 0 0", bus.wave_done, bus.wave_active); end
      end
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL drain_timeout: got no wave_done expected wave_done within 400 cycles"); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_wave();
    repeat (9) step();
    tests_run++; if (bus.launch_valid !== 1'b1 || bus.active_count !== 4'd1) begin tests_failed++; $display("FAIL sim_pre: got valid=%0b cnt=%0d expected 1 1", bus.launch_valid, bus.active_count); end
    bus.missile_done = 1;
    step();
    bus.missile_done = 0;
    tests_run++; if (bus.active_count !== 4'd1 || bus.missiles_left !== 4'd1) begin tests_failed++; $display("FAIL sim_both: got cnt=%0d left=%0d expected 1 1", bus.active_count, bus.missiles_left); end
    do_reset();
    bus.missile_done = 1;
    step();
    bus.missile_done = 0;
    tests_run++; if (bus.active_count !== 4'd0) begin tests_failed++; $display("FAIL idle_underflow: got %0d expected 0", bus.active_count); end
  endtask

  task automatic test_midwave_reset();
    do_reset();
    start_wave();
    repeat (2) step();
    start_wave();
    tests_run++; if (bus.missiles_left !== 4'd3 || bus.wave_active !== 1'b1 || bus.launch_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_ws: got left=%0d active=%0b valid=%0b expected 3 1 0", bus.missiles_left, bus.wave_active, bus.launch_valid); end
    step();
    tests_run++; if (bus.launch_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_ws_timing: got valid=%0b expected 1", bus.launch_valid); end
    rst = 1;
    model_reset();
    #1;
    tests_run++; if (bus.launch_valid !== 1'b0 || bus.launch_target !== 2'd0 || bus.active_count !== 4'd0 || bus.missiles_left !== 4'd0 || bus.wave_active !== 1'b0 || bus.wave_done !== 1'b0) begin tests_failed++; $display("FAIL async_rst: got valid=%0b tgt=%0d cnt=%0d left=%0d act=%0b done=%0b expected all 0", bus.launch_valid, bus.launch_target, bus.active_count, bus.missiles_left, bus.wave_active, bus.wave_done); end
    step();
    rst = 0;
    start_wave();
    tests_run++; if (bus.missiles_left !== 4'd3 || bus.wave_active !== 1'b1) begin tests_failed++; $display("FAIL restart: got left=%0d active=%0b expected 3 1", bus.missiles_left, bus.wave_active); end
    repeat (3) step();
    tests_run++; if (bus.launch_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_e3: got %0b expected 0", bus.launch_valid); end
    step();
    tests_run++; if (bus.launch_valid !== 1'b1) begin tests_failed++; $display("FAIL restart_e4: got %0b expected 1", bus.launch_valid); end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.wave_start   = ($urandom_range(0, 19) == 0);
      bus.target_sel   = 3'($urandom_range(0, 7));
      bus.launch_ready = ($urandom_range(0, 3) != 0);
      bus.missile_done = ($urandom_range(0, 5) == 0);
      step();
      tests_run++;
      if (bus.launch_valid !== m_valid || bus.active_count !== 4'(m_count) ||
          bus.missiles_left !== 4'(m_left) || bus.wave_active !== m_wact ||
          bus.wave_done !== m_done || (m_valid && bus.launch_target !== 2'(m_tgt))) begin
        tests_failed++;
        if (errs < 10) $display("FAIL rand_cyc%0d: got v=%0b t=%0d c=%0d l=%0d a=%0b d=%0b expected v=%0b t=%0d c=%0d l=%0d a=%0b d=%0b",
          i, bus.launch_valid, bus.launch_target, bus.active_count, bus.missiles_left, bus.wave_active, bus.wave_done,
          m_valid, m_tgt, m_count, m_left, m_wact, m_done);
        errs++;
      end
    end
    bus.wave_start = 0; bus.missile_done = 0; bus.launch_ready = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    rst = 1;
    bus.wave_start = 0; bus.target_sel = 0; bus.missile_done = 0; bus.launch_ready = 1;
    model_reset();
    test_reset();
    test_latency();
    test_capacity();
    test_backpressure();
    test_invalid_drain();
    test_simultaneous();
    test_midwave_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/enemy_missile_launch_scheduler.md
Name: enemy_missile_launch_scheduler

Overview:
Sequences enemy missile launches for one attack wave. Spaces launches by a fixed interval and caps the number of missiles in flight. Samples the current value of the enemy missile targeting shift register at each launch decision and hands a launch request, carrying the target, to the missile datapath. Sits between the game-state controller (wave start/done) and the enemy missile objects (launch handshake, missile_done pulses).

Parameters:
MISSILES_PER_WAVE, 8, missiles launched per wave (1..15)
MAX_ACTIVE, 4, maximum missiles in flight at once (1..15)
INTERVAL, 1000, minimum clock cycles between launch decisions (>=2)
TMR_W, 16, width of the interval timer; must hold INTERVAL-1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
wave_start  in  1  one-cycle pulse; starts a wave, honoured only in IDLE
target_sel  in  3  current output of the targeting shift register; valid codes 0..2
missile_done  in  1  one-cycle pulse; one in-flight missile has impacted or been destroyed
launch_ready  in  1  missile datapath accepts a launch this cycle
launch_valid  out  1  launch request
launch_target  out  2  target index for the request (0,1,2)
active_count  out  4  missiles currently in flight
missiles_left  out  4  launches remaining in the current wave
wave_active  out  1  high from wave start until wave_done
wave_done  out  1  one-cycle pulse when the wave has fully drained

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0. Timer 0. An in-progress launch request is dropped and is not completed.
- FSM states: IDLE, WAIT, LAUNCH, DRAIN. All outputs are registered.
- IDLE: on wave_start -> missiles_left=MISSILES_PER_WAVE, timer=INTERVAL-1, wave_active=1, go to WAIT. All other inputs except missile_done are ignored.
- WAIT: if timer!=0, decrement timer. If timer==0 and active_count<MAX_ACTIVE: latch the target, set launch_valid=1, go to LAUNCH. If timer==0 and active_count==MAX_ACTIVE: stay in WAIT with timer held at 0 until a slot frees.
- Latency: the first launch_valid rises exactly INTERVAL edges after the edge that captures wave_start.
- Target latch: launch_target=target_sel[1:0] when target_sel<=2. Codes 3..7 map to 0. The latched value is held stable while launch_valid=1, independent of target_sel.
- LAUNCH: hold launch_valid and launch_target until launch_ready=1. On the handshake edge:
  - missiles_left decrements by 1 and active_count increments by 1.
  - launch_valid drops on the next cycle.
  - If the new missiles_left is 0, go to DRAIN. Otherwise timer=INTERVAL-1 and go to WAIT.
  - The interval is measured from the handshake, not from the request.
- DRAIN: when active_count==0, pulse wave_done for one cycle, clear wave_active, and go to IDLE. wave_done and the IDLE transition occur on the same edge.
- active_count update rules (apply in every state):
  - +1 on a launch handshake.
  - -1 on missile_done.
  - Both in the same cycle: unchanged.
  - missile_done while count==0 and no handshake: ignored, no underflow.
  - count never exceeds MAX_ACTIVE.
- wave_start while not IDLE: ignored. It does not restart or extend the wave.
- missile_done pulses before the first launch or in IDLE: only the underflow rule applies.

Test Plan:
(Parameters for all scenarios: MISSILES_PER_WAVE=3, MAX_ACTIVE=2, INTERVAL=4, launch_ready tied 1 unless stated.)
1. Reset then wave_start at edge E0, target_sel=1 -> launch_valid=1 after E4 with launch_target=1. Handshake at E5 gives active_count=1, missiles_left=2. Next launch_valid after E9.
2. Capacity stall: no missile_done, target_sel=2 -> active_count reaches 2 after the second handshake and the FSM holds in WAIT. A missile_done pulse gives active_count=1 and launch_valid rises the next edge. The third handshake gives missiles_left=0 and state DRAIN.
3. Backpressure: launch_ready=0 for 5 cycles while target_sel changes 0->2->7 -> launch_valid stays 1 and launch_target keeps the originally latched value. Raising launch_ready completes exactly one handshake.
4. Invalid code and drain: target_sel=5 at launch decision -> launch_target=0. After the wave drains to active_count=0, wave_done=1 for exactly one cycle, wave_active=0, state IDLE.
5. Simultaneous launch handshake and missile_done with active_count=1 -> active_count stays 1 and missiles_left decrements. missile_done in IDLE with count 0 -> count stays 0.
6. wave_start pulsed mid-wave -> no effect on missiles_left. rst asserted while launch_valid=1 -> all outputs 0 immediately, then a new wave_start restarts with missiles_left=3.
